// File: rtl/regfile_wr_arbiter_if.sv
// Bundles the writeback, auxiliary, decode-hazard and register-file port
// signals that connect to the write arbiter.
interface regfile_wr_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        aux_valid;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic        aux_ready;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        pend_a;
  logic        pend_b;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        stall_req;

  modport master (
    output wb_we, wb_addr, wb_data,
    output aux_valid, aux_addr, aux_data,
    output rd_addr_a, rd_addr_b,
    input  aux_ready, pend_a, pend_b,
    input  rf_we, rf_addr, rf_data, stall_req
  );

  modport slave (
    input  wb_we, wb_addr, wb_data,
    input  aux_valid, aux_addr, aux_data,
    input  rd_addr_a, rd_addr_b,
    output aux_ready, pend_a, pend_b,
    output rf_we, rf_addr, rf_data, stall_req
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: writeback has fixed priority, auxiliary
// writes queue in a small FIFO and drain on idle cycles with starvation stall.
module regfile_wr_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wr_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [4:0]       entry_addr [DEPTH];
  logic [31:0]      entry_data [DEPTH];
  logic [DEPTH-1:0] entry_valid;
  logic [DEPTH-1:0] valid_next;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic [PW:0]      count_next;
  logic [CW-1:0]    wait_cnt;
  logic [CW-1:0]    wait_next;
  logic             stall_next;
  logic             full;
  logic             empty;
  logic             wb_win;
  logic             push;
  logic             pop;

  assign full   = (count == (PW+1)'(DEPTH));
  assign empty  = (count == '0);
  // Writes to $zero are treated as idle so the FIFO may drain that cycle.
  assign wb_win = bus.wb_we && (bus.wb_addr != 5'd0);
  assign pop    = !wb_win && !empty;

  assign bus.aux_ready = rst_n && !full;
  assign push          = bus.aux_valid && bus.aux_ready && (bus.aux_addr != 5'd0);

  assign count_next = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

  always_comb begin
    valid_next = entry_valid;
    if (pop)  valid_next[rd_ptr] = 1'b0;
    if (push) valid_next[wr_ptr] = 1'b1;
  end

  // Blocked cycles (non-empty, pipeline granted) accumulate; any drain resets.
  always_comb begin
    wait_next = wait_cnt;
    if (empty || pop)
      wait_next = '0;
    else if (wait_cnt != CW'(MAX_WAIT))
      wait_next = wait_cnt + CW'(1);
  end

  assign stall_next = (count_next != '0) &&
                      (bus.stall_req || (wait_next == CW'(MAX_WAIT)));

  always_comb begin
    bus.pend_a = 1'b0;
    bus.pend_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && entry_addr[i] == bus.rd_addr_a) bus.pend_a = 1'b1;
      if (entry_valid[i] && entry_addr[i] == bus.rd_addr_b) bus.pend_b = 1'b1;
    end
    bus.pend_a = bus.pend_a && (bus.rd_addr_a != 5'd0) && rst_n;
    bus.pend_b = bus.pend_b && (bus.rd_addr_b != 5'd0) && rst_n;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entry_addr[wr_ptr] <= bus.aux_addr;
      entry_data[wr_ptr] <= bus.aux_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_valid <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      wait_cnt    <= '0;
    end else begin
      entry_valid <= valid_next;
      count       <= count_next;
      wait_cnt    <= wait_next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Idle cycles keep the last address/data on the port; only rf_we drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rf_we     <= 1'b0;
      bus.rf_addr   <= 5'd0;
      bus.rf_data   <= 32'd0;
      bus.stall_req <= 1'b0;
    end else begin
      bus.stall_req <= stall_next;
      if (wb_win) begin
        bus.rf_we   <= 1'b1;
        bus.rf_addr <= bus.wb_addr;
        bus.rf_data <= bus.wb_data;
      end else if (pop) begin
        bus.rf_we   <= 1'b1;
        bus.rf_addr <= entry_addr[rd_ptr];
        bus.rf_data <= entry_data[rd_ptr];
      end else begin
        bus.rf_we   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared against a queue-based model.
module tb_regfile_wr_arbiter;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 8;

  logic clk;
  logic rst_n;
  logic chk_en;
  int   cmp_count;
  int   fail_count;

  regfile_wr_arbiter_if bus ();

  regfile_wr_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of {addr,data}, the registered port and the wait count.
  logic [36:0] mq[$];
  logic        m_we    = 1'b0;
  logic [4:0]  m_addr  = 5'd0;
  logic [31:0] m_data  = 32'd0;
  int          m_wait  = 0;
  logic        m_stall = 1'b0;
  int          m_n0;
  logic        m_popped;
  logic [36:0] m_head;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_we    = 1'b0;
      m_addr  = 5'd0;
      m_data  = 32'd0;
      m_wait  = 0;
      m_stall = 1'b0;
    end else begin
      m_n0     = mq.size();
      m_popped = 1'b0;
      if (bus.wb_we && bus.wb_addr != 5'd0) begin
        m_we   = 1'b1;
        m_addr = bus.wb_addr;
        m_data = bus.wb_data;
      end else if (m_n0 > 0) begin
        m_head   = mq.pop_front();
        m_popped = 1'b1;
        m_we     = 1'b1;
        m_addr   = m_head[36:32];
        m_data   = m_head[31:0];
      end else begin
        m_we = 1'b0;
      end
      if (bus.aux_valid && m_n0 < DEPTH && bus.aux_addr != 5'd0)
        mq.push_back({bus.aux_addr, bus.aux_data});
      if (m_n0 == 0 || m_popped) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
      if (mq.size() == 0) m_stall = 1'b0;
      else if (m_wait == MAX_WAIT) m_stall = 1'b1;
    end
  end

  function automatic logic modelPend(input logic [4:0] a);
    logic r;
    r = 1'b0;
    foreach (mq[i]) if (mq[i][36:32] == a) r = 1'b1;
    return r && (a != 5'd0) && rst_n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("rf_we",     32'(bus.rf_we),     32'(m_we));
      checkOutput("rf_addr",   32'(bus.rf_addr),   32'(m_addr));
      checkOutput("rf_data",   bus.rf_data,        m_data);
      checkOutput("stall_req", 32'(bus.stall_req), 32'(m_stall));
      checkOutput("aux_ready", 32'(bus.aux_ready), 32'(rst_n && mq.size() < DEPTH));
      checkOutput("pend_a",    32'(bus.pend_a),    32'(modelPend(bus.rd_addr_a)));
      checkOutput("pend_b",    32'(bus.pend_b),    32'(modelPend(bus.rd_addr_b)));
    end
  end

  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic av, input logic [4:0] aa, input logic [31:0] ad);
    bus.wb_we     = we;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
    bus.aux_valid = av;
    bus.aux_addr  = aa;
    bus.aux_data  = ad;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int wb_pct;

  initial begin
    cmp_count  = 0;
    fail_count = 0;
    chk_en     = 1'b0;
    rst_n      = 1'b1;
    bus.rd_addr_a = 5'd4;
    bus.rd_addr_b = 5'd0;
    applyStimulus(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;

    // Reset held with active requests
    repeat (3) step();
    checkOutput("rst_rf_we", 32'(bus.rf_we), 32'd0);
    checkOutput("rst_rf_data", bus.rf_data, 32'd0);
    checkOutput("rst_aux_ready", 32'(bus.aux_ready), 32'd0);
    checkOutput("rst_pend_a", 32'(bus.pend_a), 32'd0);
    checkOutput("rst_stall", 32'(bus.stall_req), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_rst", 32'(bus.aux_ready), 32'd1);

    // Pipeline priority
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    step();
    checkOutput("wb_we", 32'(bus.rf_we), 32'd1);
    checkOutput("wb_addr", 32'(bus.rf_addr), 32'd5);
    checkOutput("wb_data", bus.rf_data, 32'hDEADBEEF);
    applyStimulus(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0);
    step();
    checkOutput("wb_zero_we", 32'(bus.rf_we), 32'd0);
    checkOutput("wb_zero_hold", 32'(bus.rf_addr), 32'd5);

    // Aux drain with two-cycle latency
    bus.rd_addr_a = 5'd7;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h11);
    step();
    checkOutput("drain_e1_we", 32'(bus.rf_we), 32'd0);
    checkOutput("drain_pend", 32'(bus.pend_a), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h22);
    step();
    checkOutput("drain1_addr", 32'(bus.rf_addr), 32'd7);
    checkOutput("drain1_data", bus.rf_data, 32'h11);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    checkOutput("drain2_addr", 32'(bus.rf_addr), 32'd8);
    checkOutput("drain2_data", bus.rf_data, 32'h22);
    step();
    checkOutput("drain_idle", 32'(bus.rf_we), 32'd0);

    // Full FIFO under continuous writeback
    applyStimulus(1'b1, 5'd10, 32'hA, 1'b1, 5'd7, 32'h77);
    step();
    applyStimulus(1'b1, 5'd11, 32'hB, 1'b1, 5'd8, 32'h88);
    step();
    bus.rd_addr_a = 5'd7;
    bus.rd_addr_b = 5'd9;
    applyStimulus(1'b1, 5'd12, 32'hC, 1'b1, 5'd9, 32'h99);
    #1;
    checkOutput("full_ready", 32'(bus.aux_ready), 32'd0);
    checkOutput("full_pend_a", 32'(bus.pend_a), 32'd1);
    checkOutput("full_pend_b", 32'(bus.pend_b), 32'd0);
    step();
    checkOutput("full_wb_addr", 32'(bus.rf_addr), 32'd12);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    checkOutput("full_pop1", 32'(bus.rf_addr), 32'd7);
    step();
    checkOutput("full_pop2", bus.rf_data, 32'h88);
    step();

    // Starvation stall
    applyStimulus(1'b1, 5'd13, 32'hD, 1'b1, 5'd20, 32'h2020);
    step();
    applyStimulus(1'b1, 5'd13, 32'hD, 1'b0, 5'd0, 32'h0);
    repeat (MAX_WAIT - 1) step();
    checkOutput("stall_early", 32'(bus.stall_req), 32'd0);
    step();
    checkOutput("stall_set", 32'(bus.stall_req), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    checkOutput("stall_clear", 32'(bus.stall_req), 32'd0);
    checkOutput("stall_drain_addr", 32'(bus.rf_addr), 32'd20);
    checkOutput("stall_drain_data", bus.rf_data, 32'h2020);

    // Reset with two buffered entries
    applyStimulus(1'b1, 5'd14, 32'hE, 1'b1, 5'd21, 32'h21);
    step();
    applyStimulus(1'b1, 5'd14, 32'hE, 1'b1, 5'd22, 32'h22);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    bus.rd_addr_a = 5'd21;
    rst_n = 1'b0;
    #2;
    checkOutput("midrst_ready", 32'(bus.aux_ready), 32'd0);
    checkOutput("midrst_pend", 32'(bus.pend_a), 32'd0);
    checkOutput("midrst_we", 32'(bus.rf_we), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("midrst_no_write", 32'(bus.rf_we), 32'd0);
    end

    // Randomized traffic with varying writeback load and rare resets
    wb_pct = 70;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) wb_pct = (c / 200) % 3 == 0 ? 30 : ((c / 200) % 3 == 1 ? 75 : 97);
      applyStimulus($urandom_range(0, 99) < wb_pct, 5'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom);
      bus.rd_addr_a = 5'($urandom_range(0, 7));
      bus.rd_addr_b = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      step();
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end
endmodule
